// File: rtl/svi_rr_arbiter_if.sv
// Per-channel handshake between one master and the round-robin arbiter.
// The arbiter side (modport A) samples req/last and drives gnt; the master
// side (modport M) is the mirror image.
interface arb_if;
    logic req;
    logic last;
    logic gnt;

    modport A (input req, input last, output gnt);
    modport M (output req, output last, input gnt);
endinterface : arb_if

// File: rtl/svi_rr_arbiter.sv
// N_CH-channel round-robin arbiter with per-grant hold limit.
// One owner at a time; the grant is held until the owner drops req, signals
// its final beat with last, or the hold limit forces it off. On every release
// the arbiter re-arbitrates in the same cycle starting just past the old owner,
// so back-to-back transfers see no bubble and every channel gets its turn.
module svi_rr_arbiter #(
    parameter  int N_CH     = 8,
    parameter  int MAX_HOLD = 16,
    localparam int IDW      = $clog2(N_CH)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    arb_if.A               p [N_CH-1:0],
    output logic           o_busy,
    output logic [IDW-1:0] o_owner,
    output logic           o_timeout
);

    // Hold counter only needs to reach MAX_HOLD; keep at least one bit.
    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [IDW-1:0] IDX_LAST = IDW'(N_CH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e          state_q,   state_d;
    logic [N_CH-1:0] gnt_q,     gnt_d;
    logic [IDW-1:0]  ptr_q,     ptr_d;
    logic [IDW-1:0]  owner_q,   owner_d;
    logic            busy_q,    busy_d;
    logic [HW-1:0]   hold_q,    hold_d;
    logic            timeout_q, timeout_d;

    logic [N_CH-1:0] req_s;
    logic [N_CH-1:0] last_s;
    logic [N_CH-1:0] cand_s;
    logic [IDW:0]    pick_s;
    logic            tmo_hit_s;
    logic            release_s;
    logic [IDW-1:0]  next_idx_s;

    // Increment an owner index, wrapping N_CH-1 back to 0.
    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] idx);
        logic [IDW-1:0] res;
        if (idx == IDX_LAST) begin
            res = {IDW{1'b0}};
        end else begin
            res = idx + IDW'(1);
        end
        return res;
    endfunction

    // One-hot vector with only bit idx set.
    function automatic logic [N_CH-1:0] one_hot(input logic [IDW-1:0] idx);
        logic [N_CH-1:0] v;
        v      = {N_CH{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Circular priority scan: first candidate at or after start.
    // Result is {found, index}.
    function automatic logic [IDW:0] pick(input logic [N_CH-1:0] cand,
                                          input logic [IDW-1:0]  start);
        logic           found;
        logic [IDW-1:0] win;
        logic [IDW-1:0] idx;
        found = 1'b0;
        win   = {IDW{1'b0}};
        idx   = start;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end else begin
                found = found;
            end
            idx = inc_wrap(idx);
        end
        return {found, win};
    endfunction

    // Flatten the interface array into vectors and drive each grant from gnt_q.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign req_s[g]  = p[g].req;
        assign last_s[g] = p[g].last;

        // Channel grant is a straight copy of its registered one-hot bit.
        always_comb begin
            p[g].gnt = gnt_q[g];
        end
    end

    // Next-state logic: arbitration from IDLE, release/re-arbitration in GRANT.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        hold_d     = hold_q;
        timeout_d  = 1'b0;
        cand_s     = {N_CH{1'b0}};
        pick_s     = {(IDW + 1){1'b0}};
        tmo_hit_s  = 1'b0;
        release_s  = 1'b0;
        next_idx_s = inc_wrap(owner_q);

        case (state_q)
            ST_IDLE: begin
                cand_s = req_s;
                pick_s = pick(cand_s, ptr_q);
                if (pick_s[IDW]) begin
                    state_d = ST_GRANT;
                    gnt_d   = one_hot(pick_s[IDW-1:0]);
                    owner_d = pick_s[IDW-1:0];
                    busy_d  = 1'b1;
                    hold_d  = HOLD_ONE;
                end else begin
                    gnt_d  = {N_CH{1'b0}};
                    busy_d = 1'b0;
                end
            end

            ST_GRANT: begin
                tmo_hit_s = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
                release_s = !req_s[owner_q] || last_s[owner_q] || tmo_hit_s;
                if (release_s) begin
                    // Releasing owner sits out this round even if still requesting.
                    ptr_d     = next_idx_s;
                    timeout_d = tmo_hit_s;
                    cand_s    = req_s & ~one_hot(owner_q);
                    pick_s    = pick(cand_s, next_idx_s);
                    if (pick_s[IDW]) begin
                        gnt_d   = one_hot(pick_s[IDW-1:0]);
                        owner_d = pick_s[IDW-1:0];
                        busy_d  = 1'b1;
                        hold_d  = HOLD_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = {N_CH{1'b0}};
                        busy_d  = 1'b0;
                        hold_d  = {HW{1'b0}};
                    end
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HOLD_ONE;
                end else begin
                    hold_d = hold_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = {N_CH{1'b0}};
                busy_d  = 1'b0;
                hold_d  = {HW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= {N_CH{1'b0}};
            ptr_q     <= {IDW{1'b0}};
            owner_q   <= {IDW{1'b0}};
            busy_q    <= 1'b0;
            hold_q    <= {HW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_owner   = owner_q;
    assign o_timeout = timeout_q;

endmodule : svi_rr_arbiter

// File: tb/tb_svi_rr_arbiter.sv
// Directed and randomized bench for svi_rr_arbiter (N_CH=8, MAX_HOLD=4).
// A transaction-level model (current owner as an int, -1 when idle) predicts
// every output after each clock edge.
module tb_svi_rr_arbiter;

    localparam int N_CH     = 8;
    localparam int MAX_HOLD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] req_v;
    logic [N_CH-1:0] last_v;
    logic [N_CH-1:0] gnt_v;
    logic            busy;
    logic [2:0]      owner;
    logic            timeout;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_owner;       // -1 when nothing is granted
    int m_last_owner;  // value expected on o_owner
    int m_ptr;
    int m_hold;
    int m_tmo;

    arb_if u_ch [N_CH-1:0] ();

    for (genvar g = 0; g < N_CH; g++) begin : g_drv
        assign u_ch[g].req  = req_v[g];
        assign u_ch[g].last = last_v[g];
        assign gnt_v[g]     = u_ch[g].gnt;
    end

    svi_rr_arbiter #(.N_CH(N_CH), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .p         (u_ch),
        .o_busy    (busy),
        .o_owner   (owner),
        .o_timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requesting channel at circular distance 0.. from start, skipping excl.
    function automatic int scan(input logic [N_CH-1:0] r, input int start, input int excl);
        for (int k = 0; k < N_CH; k++) begin
            int i;
            i = (start + k) % N_CH;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    // Apply the arbitration rules for one clock edge using the inputs at that edge.
    task automatic model_edge();
        int w;
        if (rst) begin
            m_owner = -1; m_last_owner = 0; m_ptr = 0; m_hold = 0; m_tmo = 0;
        end else if (m_owner < 0) begin
            m_tmo = 0;
            w = scan(req_v, m_ptr, -1);
            if (w >= 0) begin
                m_owner = w; m_last_owner = w; m_hold = 1;
            end
        end else begin
            bit hit;
            hit   = (MAX_HOLD != 0) && (m_hold == MAX_HOLD);
            m_tmo = hit ? 1 : 0;
            if (!req_v[m_owner] || last_v[m_owner] || hit) begin
                m_ptr = (m_owner + 1) % N_CH;
                w = scan(req_v, m_ptr, m_owner);
                if (w >= 0) begin
                    m_owner = w; m_last_owner = w; m_hold = 1;
                end else begin
                    m_owner = -1; m_hold = 0;
                end
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
    endtask

    // Advance one clock, update the model, then compare all outputs.
    task automatic step(input string tag);
        logic [31:0] exp_gnt;
        @(posedge clk);
        model_edge();
        #1;
        exp_gnt = (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0;
        chk({tag, "_gnt"},   32'(gnt_v),   exp_gnt);
        chk({tag, "_busy"},  32'(busy),    (m_owner >= 0) ? 32'h1 : 32'h0);
        chk({tag, "_owner"}, 32'(owner),   32'(m_last_owner));
        chk({tag, "_tmo"},   32'(timeout), 32'(m_tmo));
    endtask

    initial begin
        m_owner = -1; m_last_owner = 0; m_ptr = 0; m_hold = 0; m_tmo = 0;

        // 1: reset with all requests high, then first grant to ch0
        rst = 1'b1; req_v = 8'hFF; last_v = 8'h00;
        step("t1_rst");
        chk("t1_rst_gnt", 32'(gnt_v), 32'h00);
        chk("t1_rst_own", 32'(owner), 32'h0);
        rst = 1'b0;
        step("t1_first");
        chk("t1_first_gnt", 32'(gnt_v), 32'h01);
        req_v = 8'h00;
        step("t1_drop");

        // 2: ch2/ch5/ch7 with last=1 -> one cycle each, 2,5,7,2,5
        req_v = 8'hA4; last_v = 8'hFF;
        step("t2_a"); chk("t2_ch2", 32'(gnt_v), 32'h04);
        step("t2_b"); chk("t2_ch5", 32'(gnt_v), 32'h20);
        step("t2_c"); chk("t2_ch7", 32'(gnt_v), 32'h80);
        step("t2_d"); chk("t2_ch2b", 32'(gnt_v), 32'h04);
        step("t2_e"); chk("t2_ch5b", 32'(gnt_v), 32'h20);
        req_v = 8'h00;
        step("t2_end");

        // 3: ch6 released -> ptr=7; ch7 wins over ch0, then ch0
        req_v = 8'h40;
        step("t3_ch6"); chk("t3_ch6", 32'(gnt_v), 32'h40);
        req_v = 8'h81;
        step("t3_ch7"); chk("t3_ch7", 32'(gnt_v), 32'h80);
        step("t3_ch0"); chk("t3_ch0", 32'(gnt_v), 32'h01);
        req_v = 8'h00;
        step("t3_end");

        // 4: ch3 never sends last -> held 4 cycles, timeout, one idle, regrant
        req_v = 8'h08; last_v = 8'h00;
        for (int c = 0; c < 4; c++) begin
            step("t4_hold");
            chk("t4_hold_gnt", 32'(gnt_v), 32'h08);
        end
        step("t4_force");
        chk("t4_force_gnt", 32'(gnt_v), 32'h00);
        chk("t4_force_tmo", 32'(timeout), 32'h1);
        step("t4_regrant");
        chk("t4_regrant_gnt", 32'(gnt_v), 32'h08);
        chk("t4_regrant_tmo", 32'(timeout), 32'h0);
        req_v = 8'h00;
        step("t4_end");

        // 5: ch4 granted, drops after 2 cycles; pending ch1 takes over at once
        req_v = 8'h12;
        step("t5_g1"); chk("t5_g1", 32'(gnt_v), 32'h10);
        step("t5_g2"); chk("t5_g2", 32'(gnt_v), 32'h10);
        req_v = 8'h02;
        step("t5_ch1"); chk("t5_ch1", 32'(gnt_v), 32'h02);
        req_v = 8'h00;
        step("t5_end");

        // 6: reset during ch6 grant -> ptr back to 0, so ch1 wins next
        req_v = 8'h40;
        step("t6_ch6"); chk("t6_ch6", 32'(gnt_v), 32'h40);
        req_v = 8'h42; rst = 1'b1;
        step("t6_rst"); chk("t6_rst_gnt", 32'(gnt_v), 32'h00);
        chk("t6_rst_tmo", 32'(timeout), 32'h0);
        rst = 1'b0;
        step("t6_ch1"); chk("t6_ch1", 32'(gnt_v), 32'h02);
        req_v = 8'h00;
        step("t6_end");

        // Randomized traffic: slowly toggling requests, sparse last, rare resets
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 79) == 0);
            req_v  = req_v ^ 8'($urandom & $urandom & $urandom);
            last_v = 8'($urandom & $urandom);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_svi_rr_arbiter
